// File: rtl/axi_txn_arbiter.sv
// axi_txn_arbiter: round-robin owner selection for the single AXI4-Lite
// master command port. Each grant runs one transaction to completion or
// timeout, then gives a one-cycle ack back to the owner.
module axi_txn_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_dir,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    err,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    m_init,
  output logic                    m_dir,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [DATA_W-1:0]       m_wdata,
  input  logic                    m_done,
  input  logic                    m_error,
  input  logic                    m_rvalid,
  input  logic [DATA_W-1:0]       m_rdata
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic                err_q, err_d;
  logic                m_done_q, m_done_d;

  logic                found;
  int unsigned         idx;
  int unsigned         win_i;

  // Cyclic search from ptr: the first requester at or after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = 0;
    win_i = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win_i = idx;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/ISSUE/WAIT/ACK sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    dir_d    = dir_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    err_d    = err_q;
    m_done_d = m_done;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_ISSUE;
          owner_d = PTR_W'(win_i);
          grant_d = N_REQ'(1) << win_i;
          dir_d   = req_dir[win_i];
          addr_d  = req_addr[win_i*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[win_i*DATA_W +: DATA_W];
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        cap_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_rvalid && !dir_q) begin
          cap_d = m_rdata;
        end
        // Edge-detect against the registered copy so a TXN_DONE still high
        // from the previous transaction cannot complete this one.
        if (m_done && !m_done_q) begin
          err_d   = m_error;
          state_d = S_ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          cap_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        ptr_d   = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        dir_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      dir_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      cap_q    <= '0;
      err_q    <= 1'b0;
      m_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      err_q    <= err_d;
      m_done_q <= m_done_d;
    end
  end

  // Outputs decode purely from registered state; ack/rdata/err only in ACK.
  always_comb begin
    ack     = (state_q == S_ACK) ? grant_q : '0;
    rdata   = (state_q == S_ACK && !dir_q) ? cap_q : '0;
    err     = (state_q == S_ACK) ? err_q : 1'b0;
    grant   = grant_q;
    busy    = (state_q != S_IDLE);
    m_init  = (state_q == S_ISSUE);
    m_dir   = dir_q;
    m_addr  = addr_q;
    m_wdata = wdata_q;
  end

endmodule

// File: doc/axi_txn_arbiter.md
# axi_txn_arbiter

Round-robin arbiter that shares the single AXI4-Lite master command port (INIT_TXN / ADDR / DATA / DIR / TXN_DONE) in front of the UART Lite between up to N_REQ register-access requesters. Example requesters: the UART command FSM and a game-side status/score writer. It grants one requester, issues one master transaction, and waits for completion or timeout. It then returns read data and error status to the owner with a one-cycle acknowledge.

## Interface
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 4, register address width
- DATA_W, 8, data width
- TIMEOUT, 1023, max WAIT cycles before forced completion (≥4)

- CLK  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- req  in  N_REQ  level request per requester; held until ack
- req_dir  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data, same packing
- ack  out  N_REQ  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data, valid only while ack is high
- err  out  1  error flag, valid only while ack is high
- grant  out  N_REQ  one-hot current owner; 0 when idle
- busy  out  1  high in any state other than IDLE
- m_init  out  1  one-cycle INIT_TXN pulse to master
- m_dir  out  1  DIR to master
- m_addr  out  ADDR_W  ADDR to master
- m_wdata  out  DATA_W  DATA to master
- m_done  in  1  TXN_DONE from master (pulse or sticky level)
- m_error  in  1  ERROR from master
- m_rvalid  in  1  read beat handshake (RVALID & RREADY)
- m_rdata  in  DATA_W  read data (RDATA[DATA_W-1:0])

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - Search req cyclically starting at pointer ptr; the first set bit wins.
  - Register the winner into grant; latch its dir/addr/wdata into m_dir/m_addr/m_wdata.
  - Go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - m_init=1 for exactly this cycle.
  - Clear the timeout counter and the rdata capture register.
  - Go to WAIT.
- WAIT:
  - Completion is a rising edge of m_done, using a registered m_done_q. A stale high TXN_DONE from the previous transaction is therefore never taken as completion.
  - On m_rvalid, capture m_rdata when m_dir=0.
  - On completion, go to ACK with err=m_error.
  - If the counter reaches TIMEOUT, go to ACK with err=1 and rdata=0.
- ACK:
  - ack[owner]=1; rdata = captured value for reads, 0 for writes.
  - ptr <= (owner+1) mod N_REQ.
  - Go to IDLE.
- m_dir/m_addr/m_wdata are held constant from ISSUE through ACK; they are zeroed on entry to IDLE.
- The owner's req is not re-sampled after grant. Dropping req early does not cancel the transaction, and ack is still pulsed.
- A requester wanting another transaction may keep req high; it then re-competes in the next IDLE behind the others (pointer already advanced).
- A late m_done after a timeout is ignored, because IDLE/ISSUE do not sample it.
- Timeout counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- ptr is clog2(N_REQ) bits; the increment wraps N_REQ-1 -> 0.

## Timing
- Reset: state IDLE, ptr=0; all outputs 0 (ack, rdata, err, grant, busy, m_init, m_dir, m_addr, m_wdata); m_done_q=0.
- Reset asserted mid-transaction: abort immediately with no ack. The master shares resetn.
- Cycle sequence for req seen in IDLE at cycle T:
  - T+1: grant/busy high, m_init=1.
  - T+2 onward: WAIT.
  - m_done rising edge seen at cycle D: ack/rdata/err at D+1.
  - D+2: IDLE; earliest next m_init at D+3.
- Fixed arbiter overhead is 3 cycles plus master latency.
- Simultaneous requests are resolved only in IDLE; requests arriving during a transaction wait.
- m_rvalid and m_done may arrive in the same cycle; the data is captured and ACK still follows on the next cycle.
- Timeout: ack at T+2+TIMEOUT+1 when m_done never rises.

## Test plan
- Single write: req[1], dir=1, addr=0x4, wdata=0x55; master done 6 cycles after m_init.
  - m_init exactly one cycle with m_addr=0x4, m_wdata=0x55, m_dir=1.
  - ack=3'b010 one cycle, err=0, rdata=0.
- Single read: req[0], addr=0x8; m_rvalid with m_rdata=0xA5, m_done one cycle later.
  - ack[0] with rdata=0xA5, err=0.
- Contention: req=3'b111 from reset, each held until its ack.
  - Grant order 0, 1, 2.
  - Then req[0] and req[2] continuously high: grants alternate 0, 2, 0, 2.
- Stale done: hold m_done=1 entering ISSUE, drop it 2 cycles later, raise it 3 cycles after that.
  - No ack until the second rising edge.
- Timeout with TIMEOUT=15: m_done never rises.
  - ack at m_init+17 with err=1, rdata=0.
  - A m_done pulse 5 cycles later produces no ack; the next request proceeds normally.
- Reset mid-WAIT: resetn=0 for one cycle.
  - All outputs 0, no ack; the next req[2] gets the first grant (ptr=0 search).
